// File: rtl/matrix_scanner.sv
`default_nettype none
// ============================================================================
// Module      : matrix_scanner
// Description : Row-multiplexed LED matrix scan driver with frame-boundary
//               shadow latch. Optional macro SCANNER_GHOST_BLANK_EN blanks the
//               columns for the first BLANK cycles of every row slot.
// Revision    : 1.0 - initial release
// ============================================================================
module matrix_scanner #(
  parameter int ROW      = 4,
  parameter int COL      = 4,
  parameter int SCAN_DIV = 1000,
  parameter int BLANK    = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [ROW*COL-1:0] frame_in,
  output logic [ROW-1:0]     row_sel,
  output logic [COL-1:0]     col_out,
  output logic               frame_start
);

  localparam int DIV_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam int ROW_W = (ROW > 1) ? $clog2(ROW) : 1;
  localparam logic [DIV_W-1:0] C_DIV_LAST  = DIV_W'(SCAN_DIV - 1);
  localparam logic [ROW_W-1:0] C_ROW_LAST  = ROW_W'(ROW - 1);
  localparam logic [DIV_W-1:0] C_BLANK_END = DIV_W'((BLANK > 0) ? BLANK - 1 : 0);

  if (SCAN_DIV < 2) begin : g_bad_scan_div
    $error("matrix_scanner: SCAN_DIV must be >= 2");
  end
  if (BLANK >= SCAN_DIV) begin : g_bad_blank
    $error("matrix_scanner: BLANK must be < SCAN_DIV");
  end

  logic [DIV_W-1:0]   r_div_cnt;
  logic [ROW_W-1:0]   r_row_idx;
  logic [ROW*COL-1:0] r_shadow;
  logic [ROW-1:0]     r_row_sel;
  logic [COL-1:0]     r_col_out;
  logic               r_frame_start;

  logic               w_slot_end;
  logic [ROW_W-1:0]   w_row_next;
  logic               w_wrap;
  logic [ROW-1:0]     w_row_onehot;

  always_comb begin
    w_slot_end   = (r_div_cnt == C_DIV_LAST);
    w_row_next   = (r_row_idx == C_ROW_LAST) ? '0 : r_row_idx + 1'b1;
    w_wrap       = (w_row_next == '0);
    w_row_onehot = ROW'(1) << w_row_next;
  end

  // Reset preloads the terminal count so the first edge is a frame wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div_cnt     <= C_DIV_LAST;
      r_row_idx     <= C_ROW_LAST;
      r_shadow      <= '0;
      r_row_sel     <= '0;
      r_col_out     <= '0;
      r_frame_start <= 1'b0;
    end else if (w_slot_end) begin
      r_div_cnt <= '0;
      r_row_idx <= w_row_next;
      r_row_sel <= w_row_onehot;
      if (w_wrap) begin
        r_shadow      <= frame_in;
        r_frame_start <= 1'b1;
      end else begin
        r_frame_start <= 1'b0;
      end
`ifdef SCANNER_GHOST_BLANK_EN
      if (BLANK > 0) begin
        r_col_out <= '0;
      end else if (w_wrap) begin
        r_col_out <= frame_in[COL-1:0];
      end else begin
        r_col_out <= r_shadow[w_row_next*COL +: COL];
      end
`else
      if (w_wrap) begin
        r_col_out <= frame_in[COL-1:0];
      end else begin
        r_col_out <= r_shadow[w_row_next*COL +: COL];
      end
`endif
    end else begin
      r_div_cnt     <= r_div_cnt + 1'b1;
      r_frame_start <= 1'b0;
`ifdef SCANNER_GHOST_BLANK_EN
      // Shadow already holds this frame, so row 0 reads it here too.
      if (BLANK > 0 && r_div_cnt == C_BLANK_END) begin
        r_col_out <= r_shadow[r_row_idx*COL +: COL];
      end
`endif
    end
  end

  assign row_sel     = r_row_sel;
  assign col_out     = r_col_out;
  assign frame_start = r_frame_start;

endmodule
`default_nettype wire

// File: tb/tb_matrix_scanner.sv
`default_nettype none
// ============================================================================
// Module      : tb_matrix_scanner
// Description : Self-checking bench for matrix_scanner (vector table plus
//               scoreboard of a cycle-indexed reference model).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_matrix_scanner;

  localparam int ROW      = 4;
  localparam int COL      = 4;
  localparam int SCAN_DIV = 4;
  localparam int BLANK    = 1;
  localparam int FRAME    = ROW * SCAN_DIV;
`ifdef SCANNER_GHOST_BLANK_EN
  localparam bit BLANK_MODE = 1'b1;
`else
  localparam bit BLANK_MODE = 1'b0;
`endif

  logic               clk = 1'b0;
  logic               rst_n = 1'b1;
  logic [ROW*COL-1:0] frame_in = '0;
  logic [ROW-1:0]     row_sel;
  logic [COL-1:0]     col_out;
  logic               frame_start;

  matrix_scanner #(
    .ROW(ROW), .COL(COL), .SCAN_DIV(SCAN_DIV), .BLANK(BLANK)
  ) dut (
    .clk(clk), .rst_n(rst_n), .frame_in(frame_in),
    .row_sel(row_sel), .col_out(col_out), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [ROW-1:0] row;
    logic [COL-1:0] col;
    logic           fs;
  } exp_t;

  typedef struct {
    logic [ROW*COL-1:0] fin;
    logic [ROW-1:0]     row;
    logic [COL-1:0]     col;
    logic               fs;
  } vec_t;

  exp_t               sb_q[$];
  int                 n_checks = 0;
  int                 n_pass   = 0;
  int                 k        = 0;
  logic [ROW*COL-1:0] m_latch  = '0;
  vec_t               vt[17];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, k - 1);
  endtask

  // Reference: output after post-reset edge kk depends only on kk and the
  // frame value captured at the most recent wrap edge.
  function automatic exp_t model(input int kk, input logic [ROW*COL-1:0] latch);
    exp_t e;
    int   ri;
    ri    = (kk / SCAN_DIV) % ROW;
    e.row = ROW'(1) << ri;
    e.col = latch[ri*COL +: COL];
    if (BLANK_MODE && (kk % SCAN_DIV) < BLANK) e.col = '0;
    e.fs  = (kk % FRAME) == 0;
    return e;
  endfunction

  task automatic tick();
    exp_t e;
    if (k % FRAME == 0) m_latch = frame_in;
    sb_q.push_back(model(k, m_latch));
    @(posedge clk);
    #1;
    k++;
    e = sb_q.pop_front();
    check("sb_row_sel", 32'(row_sel), 32'(e.row));
    check("sb_col_out", 32'(col_out), 32'(e.col));
    check("sb_frame_start", 32'(frame_start), 32'(e.fs));
    check("onehot", 32'($onehot(row_sel)), 32'd1);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_row_sel"}, 32'(row_sel), 32'd0);
    check({tag, "_col_out"}, 32'(col_out), 32'd0);
    check({tag, "_frame_start"}, 32'(frame_start), 32'd0);
  endtask

  initial begin
    logic [3:0] c0;
    int         pulses;
    int         last_pulse;
    int         guard;

    c0 = BLANK_MODE ? 4'h0 : 4'h3;
    vt[0]  = '{16'hA5C3, 4'b0001, c0,   1'b1};
    vt[1]  = '{16'hA5C3, 4'b0001, 4'h3, 1'b0};
    vt[2]  = '{16'hA5C3, 4'b0001, 4'h3, 1'b0};
    vt[3]  = '{16'hA5C3, 4'b0001, 4'h3, 1'b0};
    vt[4]  = '{16'hA5C3, 4'b0010, BLANK_MODE ? 4'h0 : 4'hC, 1'b0};
    vt[5]  = '{16'hA5C3, 4'b0010, 4'hC, 1'b0};
    vt[6]  = '{16'hA5C3, 4'b0010, 4'hC, 1'b0};
    vt[7]  = '{16'hA5C3, 4'b0010, 4'hC, 1'b0};
    vt[8]  = '{16'hA5C3, 4'b0100, BLANK_MODE ? 4'h0 : 4'h5, 1'b0};
    vt[9]  = '{16'hA5C3, 4'b0100, 4'h5, 1'b0};
    vt[10] = '{16'hA5C3, 4'b0100, 4'h5, 1'b0};
    vt[11] = '{16'hA5C3, 4'b0100, 4'h5, 1'b0};
    vt[12] = '{16'hA5C3, 4'b1000, BLANK_MODE ? 4'h0 : 4'hA, 1'b0};
    vt[13] = '{16'hA5C3, 4'b1000, 4'hA, 1'b0};
    vt[14] = '{16'hA5C3, 4'b1000, 4'hA, 1'b0};
    vt[15] = '{16'hA5C3, 4'b1000, 4'hA, 1'b0};
    vt[16] = '{16'hA5C3, 4'b0001, c0,   1'b1};

    // Power-on reset
    frame_in = 16'hA5C3;
    #3 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Basic scan from the vector table
    for (int i = 0; i < 17; i++) begin
      frame_in = vt[i].fin;
      tick();
      check("tbl_row_sel", 32'(row_sel), 32'(vt[i].row));
      check("tbl_col_out", 32'(col_out), 32'(vt[i].col));
      check("tbl_frame_start", 32'(frame_start), 32'(vt[i].fs));
    end

    // Tear-free latch and frame pulse spacing over three wraps
    pulses     = 0;
    last_pulse = -1;
    for (int i = 0; i < 49; i++) begin
      if (k == 21) frame_in = 16'hFFFF;
      tick();
      if (k - 1 == 25) check("tear_row2", 32'(col_out), 32'h5);
      if (k - 1 == 29) check("tear_row3", 32'(col_out), 32'hA);
      if (k - 1 == 33) check("new_row0", 32'(col_out), 32'hF);
      if (k - 1 == 37) check("new_row1", 32'(col_out), 32'hF);
      if (frame_start) begin
        if (last_pulse >= 0) check("pulse_spacing", 32'(k - 1 - last_pulse), 32'(FRAME));
        last_pulse = k - 1;
        pulses++;
      end
    end
    check("pulse_count", 32'(pulses), 32'd3);

    // Asynchronous reset landing in row 2
    guard = 0;
    while ((((k - 1) / SCAN_DIV) % ROW) != 2 && guard < FRAME) begin
      tick();
      guard++;
    end
    check("reach_row2", 32'(row_sel), 32'b0100);
    #2 rst_n = 1'b0;
    #1;
    check_zero("async_reset");
    frame_in = 16'h1234;
    repeat (2) @(posedge clk);
    #1;
    check_zero("held_reset");
    @(negedge clk);
    rst_n = 1'b1;
    k = 0;
    tick();
    check("restart_row_sel", 32'(row_sel), 32'b0001);
    check("restart_col_out", 32'(col_out), BLANK_MODE ? 32'h0 : 32'h4);
    check("restart_frame_start", 32'(frame_start), 32'd1);
    repeat (7) tick();
    check("restart_row1_col", 32'(col_out), 32'h3);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/matrix_scanner.md
# matrix_scanner

Row-multiplexed scan driver for the 4x4 LED matrix. Consumes the flat ROW*COL frame vector that the player/ball converters produce and time-multiplexes it onto physical row-select and column-drive lines, one row per scan slot. Frame data is shadow-latched at frame boundaries so the display never tears. Sits between the game-frame logic and the board pins.

## Interface

Parameters:
- ROW, 4, number of matrix rows
- COL, 4, number of matrix columns
- SCAN_DIV, 1000, clk cycles each row is held; must be >= 2
- BLANK, 2, blanking cycles at the start of each row slot; used only with the blanking macro; must be < SCAN_DIV

Ports (one clock; reset is asynchronous and active-low):
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- frame_in  input  ROW*COL  frame; bit r*COL+c is row r, column c, 1 = LED on
- row_sel  output  ROW  one-hot active-high row enable; bit r drives row r
- col_out  output  COL  active-high column drive for the selected row; bit c is column c
- frame_start  output  1  one-cycle pulse on the first cycle of row 0 of each frame

## Operation

- Internal state: div_cnt (width $clog2(SCAN_DIV)), row_idx (width $clog2(ROW), min 1), shadow (ROW*COL).
- Reset (async, while rst_n low): row_sel=0, col_out=0, frame_start=0, shadow=0, div_cnt=SCAN_DIV-1, row_idx=ROW-1. This preloads the terminal count, so the first edge after release is a frame wrap.
- Each rising edge, rst_n high:
  - If div_cnt==SCAN_DIV-1 (slot end):
    - div_cnt<=0.
    - row_idx<=next, where next=(row_idx==ROW-1)?0:row_idx+1.
    - row_sel<=one-hot(next).
  - If next==0 at slot end:
    - shadow<=frame_in.
    - col_out<=frame_in[COL-1:0].
    - frame_start<=1.
  - Otherwise at slot end: col_out<=shadow[next*COL +: COL], frame_start<=0.
  - Else (mid-slot): div_cnt<=div_cnt+1, frame_start<=0, row_sel and col_out hold.
- frame_in is sampled only at the row ROW-1 to row 0 wrap. Changes at any other time are invisible until the next frame.
- All outputs are registered. No combinational path from frame_in to any output.
- Reset asserted mid-frame: outputs go to 0 immediately without waiting for clk. After release, the scan restarts at row 0 with a fresh frame_in sample.

## Timing

- First edge after rst_n rises: row_sel=one-hot(0), col_out=row 0 of frame_in, frame_start=1.
- Each row is held exactly SCAN_DIV cycles. Frame period is ROW*SCAN_DIV cycles.
- frame_start is high for exactly 1 cycle per frame, coincident with the first cycle of row 0.
- row_sel is never zero after the first post-reset edge. Exactly one bit is set.
- Latency from a frame_in change to its display is at most ROW*SCAN_DIV cycles, and at least 1 cycle if the change lands just before a wrap edge.

## Configuration

- SCANNER_GHOST_BLANK_EN defined:
  - col_out is forced to 0 for the first BLANK cycles of every row slot, including row 0. This suppresses ghosting while the row drivers switch.
  - col_out then carries the row data for the remaining SCAN_DIV-BLANK cycles.
  - Blanking is registered: col_out loads 0 on the slot-end edge and loads row data on the edge where div_cnt becomes BLANK.
  - row_sel and frame_start are unaffected.
- SCANNER_GHOST_BLANK_EN undefined: col_out carries row data for the full slot. The BLANK parameter is ignored.

## Test plan

All scenarios use ROW=4, COL=4, SCAN_DIV=4, macro undefined unless stated.

- **Basic scan.** Hold rst_n=0, then release with frame_in=16'hA5C3.
  - During reset: all outputs 0.
  - Then: row_sel/col_out = 0001/3 for 4 cycles with frame_start=1 on cycle 1 only, then 0010/C, 0100/5, 1000/A.
  - Cycle 17: back to 0001/3 with frame_start=1.
- **Tear-free latch.** Start as above. Set frame_in=16'hFFFF during row 1.
  - Rows 2 and 3 still show 5 and A.
  - The next frame shows F on all rows.
- **Mid-frame reset.** Drop rst_n asynchronously (between edges) in row 2.
  - row_sel, col_out and frame_start read 0 before the next clk edge.
  - After release: row 0 of the current frame_in with frame_start=1.
- **Frame pulses.** Run 3 frames.
  - Exactly 3 frame_start pulses, spaced 16 cycles apart.
  - row_sel is one-hot on every cycle after the first post-reset edge.
- **Blanking.** SCANNER_GHOST_BLANK_EN defined, BLANK=1, frame_in=16'hA5C3.
  - Each row slot: col_out=0 on its first cycle, then row data for 3 cycles (0,3,3,3 / 0,C,C,C / ...).
  - row_sel timing is identical to the basic scan.
